kth_subsystem: RTL and testbench
================================

Name: kth_subsystem

Overview:
- APB-attached compute subsystem, slot 3 of the Edu4Chip SoC.
- Host loads an instruction memory and an input buffer (16 data words plus 8 twiddle words), then writes CALL.
- A sequential engine produces 16 output words and raises RET.
- Host polls RET or takes irq_3, then reads the output buffer.

Parameters:
- INSTR_BASE_ADDR, 32'h0105_3000, instruction memory base.
- INSTR_SIZE_BYTES, 256, instruction memory size (64 words).
- DATA_IN_BASE_ADDR, 32'h0105_3100, input buffer base.
- DATA_IN_SIZE_BYTES, 96, input buffer size (24 words: 0-15 data, 16-23 twiddle).
- DATA_OUT_BASE_ADDR, 32'h0105_3200, output buffer base.
- DATA_OUT_SIZE_BYTES, 64, output buffer size (16 words).
- CTRL_BASE_ADDR, 32'h0105_3300, control block base.
- CTRL_SIZE_BYTES, 12, control block size (3 registers).

Ports:
- clk_in  in  1  sole clock.
- reset_int  in  1  asynchronous active-low reset.
- PADDR  in  32  APB address.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  APB write.
- PWDATA  in  32  APB write data.
- PRDATA  out  32  APB read data.
- PREADY  out  1  constant 1.
- PSLVERR  out  1  error flag, unmapped access.
- high_speed_clk  in  1  reserved, unused.
- irq_3  out  1  completion interrupt.
- irq_en_3  in  1  interrupt enable.
- ss_ctrl_3  in  8  reserved, unused.
- pmod_gpi  in  16  reserved, unused.
- pmod_gpo  out  16  mirrors SEL[15:0].
- pmod_gpio_oe  out  16  16'hFFFF when out of reset, 0 in reset.

Behaviour:
- Decode: region hit when base <= PADDR < base+size. Word index = (PADDR-base)>>2; PADDR[1:0] ignored.
- Control registers:
  - CTRL+0 SEL: 32-bit read/write (row/col select).
  - CTRL+4 CALL: write-only, reads 0.
  - CTRL+8 RET: read-only, bit0 = done, other bits 0.
- Write: on every rising edge with PSEL&PENABLE&PWRITE. No wait states. Back-to-back writes with PENABLE held high are each accepted, one per cycle.
- Writable regions: instr, data_in, SEL, CALL. Writes to data_out or RET are dropped with PSLVERR=0.
- Read: PRDATA is combinational from PADDR whenever PSEL=1 and PWRITE=0; otherwise 0. Reads of data_out, data_in, instr, SEL and RET all return contents.
- PSLVERR=1 only when PSEL&PENABLE and no region hit. PRDATA=0 then; the write is ignored.
- Reset: all memories, SEL, out buffer, RET, busy and index cleared to 0. irq_3=0, pmod_gpo=0.
- Engine FSM:
  - States IDLE and RUN; 4-bit index i.
  - IDLE: a write of PWDATA[0]=1 to CALL (edge k) sets RUN, i=0, RET=0. CALL with bit0=0 is ignored.
  - RUN, each edge k+1+i: tw=in[16+(i&7)]; out[i] = instr[i][0] ? in[i]-tw : in[i]+tw, mod 2^32 (wrap, no saturation); i++.
  - At edge k+16 (i=15): write last word, go to IDLE, RET=1.
- Latency: RET visible 16 cycles after the CALL edge.
- CALL while RUN: ignored. Engine is not restarted and RET stays 0.
- Host writes to in/instr during RUN: accepted. The engine reads current contents at its step.
- Host write and engine write to the same word: cannot happen, the host cannot write data_out.
- RET is sticky until the next accepted CALL.
- Reset mid-RUN: returns to IDLE, buffers cleared, RET=0.
- Instruction words 16-63: storage only.

Optional Feature:
- Macro KTH_SS_IRQ_EN.
- Defined: irq_3 = RET & irq_en_3, registered, one cycle after RET rises; it drops one cycle after a new CALL or after irq_en_3=0.
- Undefined: irq_3 tied 0 and irq_en_3 ignored.

Test Plan:
- Reset then reads: read CTRL+8, data_out[0] and CTRL+0 -> all return 0, PSLVERR=0.
- Load and run, add:
  - Stimulus: instr all 0, in[i]=i+1, in[16+j]=100*j; CALL=1.
  - Response: RET stays 0 for 15 cycles and is 1 at cycle 16; out[0]=1, out[9]=110, out[15]=716.
- Subtract with wrap: instr[3]=1, in[3]=0, in[19]=5 -> out[3]=32'hFFFF_FFFB.
- CALL during RUN: second CALL at cycle 5 -> RET still rises at cycle 16 from the first CALL; outputs unchanged.
- Unmapped access: write 32'hDEAD to 32'h0105_330C (CTRL+12) -> PSLVERR=1 during access and no state change. A write to data_out base -> PSLVERR=0 and the word stays unchanged.
- Reset mid-run and irq:
  - Assert reset_int=0 at cycle 8 of RUN -> RET=0 and out[0]=0 after release.
  - With KTH_SS_IRQ_EN and irq_en_3=1, a full run -> irq_3 rises one cycle after RET.

Source files
------------

// File: rtl/kth_subsystem.sv
// kth_subsystem: APB-attached compute block (SoC slot 3).
// The host fills an instruction memory and an input buffer (16 data words plus
// 8 twiddle words), then writes CALL. The engine walks the 16 data words one per
// cycle, adding or subtracting a twiddle word, and raises RET when finished.
// Optional feature macro: KTH_SS_IRQ_EN enables the registered completion
// interrupt irq_3 = RET & irq_en_3. Without it irq_3 is tied low.
//
// APB handshake: the slave never stalls (PREADY=1). A write is taken on every
// rising edge where PSEL&PENABLE&PWRITE are high, so holding PENABLE high while
// changing PADDR/PWDATA gives one write per cycle. Reads are combinational from
// PADDR while PSEL=1 and PWRITE=0 and have no side effects.
module kth_subsystem #(
  parameter logic [31:0] INSTR_BASE_ADDR     = 32'h0105_3000,
  parameter logic [31:0] INSTR_SIZE_BYTES    = 32'd256,
  parameter logic [31:0] DATA_IN_BASE_ADDR   = 32'h0105_3100,
  parameter logic [31:0] DATA_IN_SIZE_BYTES  = 32'd96,
  parameter logic [31:0] DATA_OUT_BASE_ADDR  = 32'h0105_3200,
  parameter logic [31:0] DATA_OUT_SIZE_BYTES = 32'd64,
  parameter logic [31:0] CTRL_BASE_ADDR      = 32'h0105_3300,
  parameter logic [31:0] CTRL_SIZE_BYTES     = 32'd12
) (
  input  logic        clk_in,
  input  logic        reset_int,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        high_speed_clk,
  output logic        irq_3,
  input  logic        irq_en_3,
  input  logic [7:0]  ss_ctrl_3,
  input  logic [15:0] pmod_gpi,
  output logic [15:0] pmod_gpo,
  output logic [15:0] pmod_gpio_oe,
  output logic [4:0]  dbg_engine   // {running, step index}
);

  typedef enum logic {IDLE, RUN} state_t;

  logic [31:0] instr_mem [64];
  logic [31:0] in_mem    [24];
  logic [31:0] out_mem   [16];
  logic [31:0] sel_q;
  logic        ret_q, ret_d;
  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        out_we;
  logic [31:0] out_val, tw;

  logic hit_instr, hit_in, hit_out, hit_ctrl, any_hit, wr_en, call_req;
  logic [5:0] instr_idx;
  logic [4:0] in_idx;
  logic [3:0] out_idx;
  logic [1:0] ctrl_idx;

  assign hit_instr = (PADDR >= INSTR_BASE_ADDR) && (PADDR < INSTR_BASE_ADDR + INSTR_SIZE_BYTES);
  assign hit_in    = (PADDR >= DATA_IN_BASE_ADDR) && (PADDR < DATA_IN_BASE_ADDR + DATA_IN_SIZE_BYTES);
  assign hit_out   = (PADDR >= DATA_OUT_BASE_ADDR) && (PADDR < DATA_OUT_BASE_ADDR + DATA_OUT_SIZE_BYTES);
  assign hit_ctrl  = (PADDR >= CTRL_BASE_ADDR) && (PADDR < CTRL_BASE_ADDR + CTRL_SIZE_BYTES);
  assign any_hit   = hit_instr | hit_in | hit_out | hit_ctrl;

  // Word indices; the byte offset bits PADDR[1:0] drop out in the shift.
  assign instr_idx = 6'((PADDR - INSTR_BASE_ADDR) >> 2);
  assign in_idx    = 5'((PADDR - DATA_IN_BASE_ADDR) >> 2);
  assign out_idx   = 4'((PADDR - DATA_OUT_BASE_ADDR) >> 2);
  assign ctrl_idx  = 2'((PADDR - CTRL_BASE_ADDR) >> 2);

  assign wr_en    = PSEL & PENABLE & PWRITE;
  assign call_req = wr_en & hit_ctrl & (ctrl_idx == 2'd1) & PWDATA[0];

  assign PREADY       = 1'b1;
  assign PSLVERR      = PSEL & PENABLE & ~any_hit;
  assign pmod_gpo     = sel_q[15:0];
  assign pmod_gpio_oe = {16{reset_int}};
  assign dbg_engine   = {state_q == RUN, idx_q};

  // Combinational read mux; unmapped or write cycles return 0.
  always_comb begin
    PRDATA = 32'd0;
    if (PSEL && !PWRITE) begin
      if (hit_instr)      PRDATA = instr_mem[instr_idx];
      else if (hit_in)    PRDATA = in_mem[in_idx];
      else if (hit_out)   PRDATA = out_mem[out_idx];
      else if (hit_ctrl) begin
        case (ctrl_idx)
          2'd0:    PRDATA = sel_q;
          2'd2:    PRDATA = {31'd0, ret_q};
          default: PRDATA = 32'd0;
        endcase
      end
    end
  end

  // Engine next-state: CALL starts a 16-step pass; CALL while running is ignored.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ret_d   = ret_q;
    out_we  = 1'b0;
    tw      = in_mem[{2'b10, idx_q[2:0]}];
    out_val = instr_mem[{2'b00, idx_q}][0] ? in_mem[{1'b0, idx_q}] - tw
                                           : in_mem[{1'b0, idx_q}] + tw;
    case (state_q)
      IDLE: begin
        if (call_req) begin
          state_d = RUN;
          idx_d   = 4'd0;
          ret_d   = 1'b0;
        end
      end
      RUN: begin
        out_we = 1'b1;
        idx_d  = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d = IDLE;
          ret_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Engine state register.
  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ret_q   <= ret_d;
    end
  end

  // Host-writable storage: instruction memory, input buffer and SEL.
  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      for (int i = 0; i < 64; i++) instr_mem[i] <= 32'd0;
      for (int i = 0; i < 24; i++) in_mem[i] <= 32'd0;
      sel_q <= 32'd0;
    end else if (wr_en) begin
      if (hit_instr) instr_mem[instr_idx] <= PWDATA;
      if (hit_in)    in_mem[in_idx] <= PWDATA;
      if (hit_ctrl && ctrl_idx == 2'd0) sel_q <= PWDATA;
    end
  end

  // Output buffer, written only by the engine.
  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      for (int i = 0; i < 16; i++) out_mem[i] <= 32'd0;
    end else if (out_we) begin
      out_mem[idx_q] <= out_val;
    end
  end

`ifdef KTH_SS_IRQ_EN
  logic irq_q;
  // Registered interrupt: follows RET gated by the enable, one cycle later.
  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) irq_q <= 1'b0;
    else            irq_q <= ret_q & irq_en_3;
  end
  assign irq_3 = irq_q;
  logic unused_inputs;
  assign unused_inputs = ^{high_speed_clk, ss_ctrl_3, pmod_gpi};
`else
  assign irq_3 = 1'b0;
  logic unused_inputs;
  assign unused_inputs = ^{high_speed_clk, ss_ctrl_3, pmod_gpi, irq_en_3};
`endif

endmodule

// File: tb/tb_kth_subsystem.sv
// Directed bench for kth_subsystem: APB load, run, boundary and reset cases.
module tb_kth_subsystem;

  localparam logic [31:0] INSTR = 32'h0105_3000;
  localparam logic [31:0] DIN   = 32'h0105_3100;
  localparam logic [31:0] DOUT  = 32'h0105_3200;
  localparam logic [31:0] CTRL  = 32'h0105_3300;
`ifdef KTH_SS_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk, reset_int;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic        irq_3, irq_en_3;
  logic [15:0] pmod_gpo, pmod_gpio_oe;
  logic [4:0]  dbg_engine;

  int n_vec = 0;
  int n_err = 0;

  kth_subsystem dut (
    .clk_in(clk), .reset_int(reset_int),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .high_speed_clk(1'b0), .irq_3(irq_3), .irq_en_3(irq_en_3),
    .ss_ctrl_3(8'd0), .pmod_gpi(16'd0), .pmod_gpo(pmod_gpo),
    .pmod_gpio_oe(pmod_gpio_oe), .dbg_engine(dbg_engine)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
    @(negedge clk);
    PADDR = addr; PWDATA = data; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge clk);
    PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(posedge clk);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic peek(input logic [31:0] addr, output logic [31:0] data, output logic err);
    PADDR = addr; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b1;
    #1;
    data = PRDATA; err = PSLVERR;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Back-to-back burst into the input buffer with PENABLE held high.
  task automatic load_in_burst(input logic [31:0] vals [24]);
    @(negedge clk);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = DIN; PWDATA = vals[0];
    @(negedge clk);
    PENABLE = 1'b1;
    for (int i = 0; i < 24; i++) begin
      PADDR = DIN + 32'(4 * i); PWDATA = vals[i];
      @(negedge clk);
    end
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e;
    reset_int = 1'b0; irq_en_3 = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'd0; PWDATA = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (pmod_gpio_oe !== 16'h0000) begin n_err++; $display("FAIL oe_in_reset got %h want 0000", pmod_gpio_oe); end
    @(negedge clk); reset_int = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (pmod_gpio_oe !== 16'hFFFF) begin n_err++; $display("FAIL oe_after_reset got %h want ffff", pmod_gpio_oe); end
    peek(CTRL + 8, d, e);
    n_vec++; if (d !== 32'd0 || e !== 1'b0) begin n_err++; $display("FAIL reset_ret got %h err %b want 0 err 0", d, e); end
    peek(DOUT, d, e);
    n_vec++; if (d !== 32'd0 || e !== 1'b0) begin n_err++; $display("FAIL reset_out0 got %h err %b want 0 err 0", d, e); end
    peek(CTRL, d, e);
    n_vec++; if (d !== 32'd0 || e !== 1'b0) begin n_err++; $display("FAIL reset_sel got %h err %b want 0 err 0", d, e); end
    n_vec++; if (irq_3 !== 1'b0 || pmod_gpo !== 16'd0) begin n_err++; $display("FAIL reset_irq_gpo got %b %h want 0 0000", irq_3, pmod_gpo); end
  endtask

  task automatic test_add();
    logic [31:0] vals [24]; logic [31:0] d, exp_v; logic e;
    for (int i = 0; i < 16; i++) vals[i] = 32'(i + 1);
    for (int j = 0; j < 8; j++) vals[16 + j] = 32'(100 * j);
    for (int i = 0; i < 16; i++) apb_write(INSTR + 32'(4 * i), 32'd0, e);
    load_in_burst(vals);
    apb_write(CTRL, 32'h1234_A5C3, e);
    n_vec++; if (pmod_gpo !== 16'hA5C3) begin n_err++; $display("FAIL sel_gpo got %h want a5c3", pmod_gpo); end
    peek(CTRL, d, e);
    n_vec++; if (d !== 32'h1234_A5C3) begin n_err++; $display("FAIL sel_read got %h want 1234a5c3", d); end
    peek(DIN + 32'd92, d, e);
    n_vec++; if (d !== 32'd700 || e !== 1'b0) begin n_err++; $display("FAIL in23_read got %h err %b want 2bc", d, e); end
    apb_write(CTRL + 4, 32'd1, e);
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      peek(CTRL + 8, d, e);
      n_vec++; if (d !== ((c == 16) ? 32'd1 : 32'd0)) begin n_err++; $display("FAIL add_ret_c%0d got %h want %0d", c, d, c == 16); end
    end
    for (int i = 0; i < 16; i++) begin
      exp_v = 32'(i + 1 + 100 * (i % 8));
      peek(DOUT + 32'(4 * i), d, e);
      n_vec++; if (d !== exp_v) begin n_err++; $display("FAIL add_out%0d got %0d want %0d", i, d, exp_v); end
    end
    peek(DOUT + 32'd36, d, e);
    n_vec++; if (d !== 32'd110) begin n_err++; $display("FAIL add_out9_const got %0d want 110", d); end
    peek(DOUT + 32'd60, d, e);
    n_vec++; if (d !== 32'd716) begin n_err++; $display("FAIL add_out15_const got %0d want 716", d); end
    peek(CTRL + 4, d, e);
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL call_reads0 got %h want 0", d); end
  endtask

  task automatic test_sub_wrap();
    logic [31:0] d; logic e;
    apb_write(INSTR + 32'd12, 32'd1, e);
    apb_write(DIN + 32'd12, 32'd0, e);
    apb_write(DIN + 32'd76, 32'd5, e);
    apb_write(CTRL + 4, 32'd1, e);
    repeat (16) @(posedge clk);
    #1;
    peek(CTRL + 8, d, e);
    n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL sub_ret got %h want 1", d); end
    peek(DOUT + 32'd12, d, e);
    n_vec++; if (d !== 32'hFFFF_FFFB) begin n_err++; $display("FAIL sub_out3 got %h want fffffffb", d); end
    peek(DOUT + 32'd44, d, e);
    n_vec++; if (d !== 32'd17) begin n_err++; $display("FAIL sub_out11 got %0d want 17", d); end
    peek(DOUT, d, e);
    n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL sub_out0 got %0d want 1", d); end
    // CALL with bit0 clear must not start the engine.
    apb_write(CTRL + 4, 32'd2, e);
    repeat (3) @(posedge clk);
    #1;
    peek(CTRL + 8, d, e);
    n_vec++; if (d !== 32'd1 || dbg_engine[4] !== 1'b0) begin n_err++; $display("FAIL call_bit0_clear ret %h run %b want 1 0", d, dbg_engine[4]); end
  endtask

  task automatic test_call_during_run();
    logic [31:0] d; logic e;
    apb_write(CTRL + 4, 32'd1, e);
    repeat (3) @(posedge clk);
    #1;
    apb_write(CTRL + 4, 32'd1, e);   // lands on cycle 5 of the run
    for (int c = 6; c <= 16; c++) begin
      @(posedge clk); #1;
      peek(CTRL + 8, d, e);
      n_vec++; if (d !== ((c == 16) ? 32'd1 : 32'd0)) begin n_err++; $display("FAIL rerun_ret_c%0d got %h want %0d", c, d, c == 16); end
    end
    repeat (4) @(posedge clk);
    #1;
    peek(CTRL + 8, d, e);
    n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL rerun_ret_late got %h want 1", d); end
    peek(DOUT + 32'd12, d, e);
    n_vec++; if (d !== 32'hFFFF_FFFB) begin n_err++; $display("FAIL rerun_out3 got %h want fffffffb", d); end
    peek(DOUT + 32'd60, d, e);
    n_vec++; if (d !== 32'd716) begin n_err++; $display("FAIL rerun_out15 got %0d want 716", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic e;
    apb_write(CTRL + 12, 32'hDEAD, e);
    n_vec++; if (e !== 1'b1) begin n_err++; $display("FAIL unmapped_wr_err got %b want 1", e); end
    peek(CTRL + 12, d, e);
    n_vec++; if (e !== 1'b1 || d !== 32'd0) begin n_err++; $display("FAIL unmapped_rd got %h err %b want 0 err 1", d, e); end
    peek(CTRL, d, e);
    n_vec++; if (d !== 32'h1234_A5C3) begin n_err++; $display("FAIL unmapped_sel got %h want 1234a5c3", d); end
    peek(CTRL + 8, d, e);
    n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL unmapped_ret got %h want 1", d); end
    peek(DIN + 32'd96, d, e);
    n_vec++; if (e !== 1'b1) begin n_err++; $display("FAIL din_end_err got %b want 1", e); end
    apb_write(DOUT, 32'h1234, e);
    n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL dout_wr_err got %b want 0", e); end
    peek(DOUT, d, e);
    n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL dout_unchanged got %h want 1", d); end
    apb_write(INSTR + 32'd252, 32'hCAFE, e);
    peek(INSTR + 32'd253, d, e);   // byte offset bits ignored
    n_vec++; if (d !== 32'hCAFE || e !== 1'b0) begin n_err++; $display("FAIL instr63 got %h err %b want cafe", d, e); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] d; logic e;
    apb_write(CTRL + 4, 32'd1, e);
    repeat (8) @(posedge clk);
    #1 reset_int = 1'b0;
    #1;
    n_vec++; if (pmod_gpio_oe !== 16'd0 || dbg_engine !== 5'd0) begin n_err++; $display("FAIL midrst_hold oe %h dbg %h want 0 0", pmod_gpio_oe, dbg_engine); end
    @(negedge clk); reset_int = 1'b1;
    #1;
    peek(CTRL + 8, d, e);
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL midrst_ret got %h want 0", d); end
    peek(DOUT, d, e);
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL midrst_out0 got %h want 0", d); end
    peek(DIN, d, e);
    n_vec++; if (d !== 32'd0 || pmod_gpo !== 16'd0) begin n_err++; $display("FAIL midrst_in0_gpo got %h %h want 0 0", d, pmod_gpo); end
    repeat (20) @(posedge clk);
    #1;
    peek(CTRL + 8, d, e);
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL midrst_idle_ret got %h want 0", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d; logic e;
    irq_en_3 = 1'b1;
    apb_write(CTRL + 4, 32'd1, e);
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk); #1;
      peek(CTRL + 8, d, e);
      n_vec++; if (d !== ((c >= 16) ? 32'd1 : 32'd0)) begin n_err++; $display("FAIL irq_ret_c%0d got %h want %0d", c, d, c >= 16); end
      n_vec++; if (irq_3 !== (IRQ_ON && c >= 17)) begin n_err++; $display("FAIL irq_c%0d got %b want %b", c, irq_3, IRQ_ON && c >= 17); end
    end
    irq_en_3 = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (irq_3 !== 1'b0) begin n_err++; $display("FAIL irq_en_off got %b want 0", irq_3); end
    irq_en_3 = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (irq_3 !== IRQ_ON) begin n_err++; $display("FAIL irq_en_on got %b want %b", irq_3, IRQ_ON); end
    apb_write(CTRL + 4, 32'd1, e);
    n_vec++; if (irq_3 !== IRQ_ON) begin n_err++; $display("FAIL irq_at_call got %b want %b", irq_3, IRQ_ON); end
    @(posedge clk); #1;
    n_vec++; if (irq_3 !== 1'b0) begin n_err++; $display("FAIL irq_after_call got %b want 0", irq_3); end
    repeat (20) @(posedge clk);
  endtask

  // Sequencer and final report
  initial begin
    test_reset();
    test_add();
    test_sub_wrap();
    test_call_during_run();
    test_unmapped();
    test_reset_mid_run();
    test_irq();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
